snn_io_ctrl: RTL and testbench
==============================

Name: snn_io_ctrl

Overview:
Top-level sequencer for the SNN digit classifier. Receives a 784-pixel binary image as 98 UART bytes and unpacks each byte into 8 single-bit writes to the input-image RAM. It then starts the SNN core, waits for the classified digit, and returns that digit to the PC through the UART transmitter. Sits inside SNN, between uart_rx/uart_tx and the core.

Parameters:
NUM_BYTES, 98, bytes per image (784/8)
ADDR_W, 10, input-RAM bit-address width (covers 0..783)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_rdy  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received byte
ram_we  out  1  input-RAM write enable
ram_addr  out  ADDR_W  input-RAM bit address
ram_wdata  out  1  input-RAM write data
core_start  out  1  one-cycle start pulse to SNN core
core_done  in  1  one-cycle pulse: core_digit valid
core_digit  in  4  classified digit 0..9
tx_start  out  1  one-cycle transmit request
tx_data  out  8  byte to transmit
tx_rdy  in  1  high while uart_tx is idle
led  out  8  last classified digit, {4'h0,digit}
busy  out  1  high outside LOAD state
overrun  out  1  sticky: a received byte was lost

Behaviour:
- Reset (async, rst_n=0): state=LOAD, byte_cnt=0, bit_cnt=0, hold register empty. All outputs 0: ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data, led, busy, overrun.
- LOAD: wait for rx_rdy, or for a pending hold register. Latch the byte into shift register sr, bit_cnt=0, go to UNPACK the next cycle.
- UNPACK: 8 consecutive cycles, each with ram_we=1, ram_addr=byte_cnt*8+bit_cnt, ram_wdata=sr[bit_cnt] (LSB first).
  - A byte accepted in cycle N is written in cycles N+1..N+8.
  - After bit 7: if byte_cnt==NUM_BYTES-1, clear byte_cnt and go to START; otherwise increment byte_cnt and return to LOAD.
- rx_rdy during UNPACK: store the byte in a 1-entry hold register. LOAD consumes it the cycle after UNPACK ends.
- rx_rdy while the hold register is full: drop the byte and set overrun.
- START: core_start=1 for exactly one cycle, then COMPUTE.
- COMPUTE: wait for core_done. On core_done, latch led={4'h0,core_digit} and tx_data={4'h0,core_digit}, then go to TX.
- TX: hold until tx_rdy=1, then assert tx_start for one cycle and go to TX_WAIT.
- TX_WAIT: wait until tx_rdy has been seen low and then high again. Then return to LOAD with busy=0.
- rx_rdy in START, COMPUTE, TX or TX_WAIT: byte dropped, overrun set.
- overrun clears only on reset.
- busy=1 in every state except LOAD. LOAD with a pending hold byte counts as busy.
- ram_we is 0 in every state except UNPACK. core_start and tx_start are never high for more than one cycle.
- byte_cnt never exceeds NUM_BYTES-1. ram_addr never exceeds 783.
- Reset mid-image abandons the partial image; the next image starts at address 0.
- core_done outside COMPUTE is ignored.
- led holds its value until the next core_done.

Test Plan:
- Full image: send 98 bytes via uart_tx (byte0=8'hA5) -> addresses 0..7 written with 1,0,1,0,0,1,0,1; final write at addr 783; one core_start pulse; no overrun.
- Classify and return: core_done with core_digit=4'd3 -> led=8'h03; exactly one tx_start with tx_data=8'h03; PC uart_rx receives 8'h03; busy falls after tx_rdy re-rises.
- Back-to-back bytes: second rx_rdy 3 cycles after the first -> held, then unpacked right after the first byte's 8 writes; addresses contiguous 0..15; overrun=0.
- Overflow: three rx_rdy strobes within 8 cycles -> third byte dropped, overrun=1 and stays 1.
- Byte during COMPUTE: rx_rdy with 8'hFF -> no ram_we, overrun=1; the following image still loads from addr 0.
- Reset mid-image: assert rst_n=0 after 40 bytes -> all outputs 0 immediately; a fresh 98-byte image writes addresses 0..783 and triggers core_start.

Source files
------------

// File: rtl/snn_io_ctrl.sv
// Image loader and classification sequencer for the SNN digit classifier.
// Unpacks UART bytes into bit writes, runs the core, and returns the digit over UART.
module snn_io_ctrl #(
  parameter int unsigned NUM_BYTES = 98,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic [7:0]        led,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned CntW = $clog2(NUM_BYTES);

  typedef enum logic [2:0] {
    StLoad,
    StUnpack,
    StStart,
    StCompute,
    StTx,
    StTxWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic            seen_low_q, seen_low_d;
  logic [7:0]      led_q, led_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      seen_low_q <= 1'b0;
      led_q      <= '0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      seen_low_q <= seen_low_d;
      led_q      <= led_d;
      tx_data_q  <= tx_data_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    seen_low_d = seen_low_q;
    led_d      = led_q;
    tx_data_d  = tx_data_q;
    overrun_d  = overrun_q;
    ram_we     = 1'b0;
    core_start = 1'b0;
    tx_start   = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (hold_vld_q) begin
          // Drain the held byte; a strobe in the same cycle refills the hold slot.
          sr_d      = hold_q;
          bit_cnt_d = '0;
          state_d   = StUnpack;
          if (rx_rdy) hold_d = rx_data;
          else        hold_vld_d = 1'b0;
        end else if (rx_rdy) begin
          sr_d      = rx_data;
          bit_cnt_d = '0;
          state_d   = StUnpack;
        end
      end
      StUnpack: begin
        ram_we    = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (byte_cnt_q == CntW'(NUM_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = StStart;
          end else begin
            byte_cnt_d = byte_cnt_q + CntW'(1);
            state_d    = StLoad;
          end
        end
        if (rx_rdy) begin
          if (hold_vld_q) begin
            overrun_d = 1'b1;
          end else begin
            hold_d     = rx_data;
            hold_vld_d = 1'b1;
          end
        end
      end
      StStart: begin
        core_start = 1'b1;
        state_d    = StCompute;
      end
      StCompute: begin
        if (core_done) begin
          led_d     = {4'h0, core_digit};
          tx_data_d = {4'h0, core_digit};
          state_d   = StTx;
        end
      end
      StTx: begin
        if (tx_rdy) begin
          tx_start   = 1'b1;
          seen_low_d = 1'b0;
          state_d    = StTxWait;
        end
      end
      StTxWait: begin
        // Finish only after the transmitter has gone busy and returned to idle.
        if (!tx_rdy)         seen_low_d = 1'b1;
        else if (seen_low_q) state_d    = StLoad;
      end
      default: state_d = StLoad;
    endcase

    if (rx_rdy && (state_q != StLoad) && (state_q != StUnpack)) overrun_d = 1'b1;
  end

  assign ram_addr  = ADDR_W'({byte_cnt_q, bit_cnt_q});
  assign ram_wdata = sr_q[bit_cnt_q];
  assign tx_data   = tx_data_q;
  assign led       = led_q;
  assign busy      = (state_q != StLoad) || hold_vld_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_snn_io_ctrl.sv
// Self-checking bench for snn_io_ctrl: random images against a bit-level image model,
// directed timing cases for hold/overrun, classification return and mid-image reset.
module tb_snn_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_wdata;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [3:0] core_digit = '0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_rdy = 1'b1;
  logic [7:0] led;
  logic       busy;
  logic       overrun;

  snn_io_ctrl #(.NUM_BYTES(98), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_rdy     (tx_rdy),
    .led        (led),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_pass = 0;
  int         wr_addr[$];
  bit         wr_data[$];
  int         wr_cyc[$];
  int         n_start = 0;
  int         n_tx = 0;
  int         n_dbl = 0;
  logic [7:0] tx_got = '0;
  logic [7:0] img[0:97];
  int         strobe_cyc;

  // Observer: logs RAM writes and pulse events at the falling edge.
  initial begin
    logic prev_cs, prev_ts;
    prev_cs = 1'b0;
    prev_ts = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_we) begin
        wr_addr.push_back(int'(ram_addr));
        wr_data.push_back(ram_wdata);
        wr_cyc.push_back(int'(cyc));
      end
      if (core_start) n_start++;
      if (tx_start) begin
        n_tx++;
        tx_got = tx_data;
      end
      if ((core_start && prev_cs) || (tx_start && prev_ts)) n_dbl++;
      prev_cs = core_start;
      prev_ts = tx_start;
    end
  end

  // Stand-in for uart_tx: goes busy shortly after a request, idle again later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (2) @(posedge clk);
        #1 tx_rdy = 1'b0;
        repeat (15) @(posedge clk);
        #1 tx_rdy = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_rdy = 1'b1;
    rx_data = b;
    strobe_cyc = int'(cyc);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic send_img(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      send(img[k]);
      idle(7 + int'($urandom_range(0, 3)));
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic rand_img();
    for (int k = 0; k < 98; k++) img[k] = 8'($urandom);
  endtask

  // Model: the n-th logged write must hit bit address n with image bit n (LSB first).
  function automatic int bad_writes(input int upto);
    int err = 0;
    for (int i = 0; i < upto && i < wr_addr.size(); i++) begin
      logic [7:0] b;
      b = img[i / 8];
      if (wr_addr[i] != i || wr_data[i] != b[i % 8]) err++;
    end
    return err;
  endfunction

  task automatic check_image(input string tag);
    chk({tag, "_wr_count"}, wr_addr.size(), 784);
    chk({tag, "_bits"}, bad_writes(784), 0);
    if (wr_addr.size() > 0) chk({tag, "_last_addr"}, wr_addr[wr_addr.size() - 1], 783);
  endtask

  task automatic wait_start(input string tag, input int s0);
    for (int i = 0; i < 400 && n_start == s0; i++) @(posedge clk);
    @(negedge clk);
    chk({tag, "_core_start"}, n_start - s0, 1);
  endtask

  task automatic classify(input string tag, input logic [3:0] d);
    int t0;
    idle(3);
    @(negedge clk);
    chk({tag, "_busy_compute"}, busy, 1);
    t0 = n_tx;
    @(posedge clk);
    #1 core_done = 1'b1;
    core_digit = d;
    @(posedge clk);
    #1 core_done = 1'b0;
    for (int i = 0; i < 100 && n_tx == t0; i++) @(posedge clk);
    @(negedge clk);
    chk({tag, "_led"}, led, {4'h0, d});
    chk({tag, "_tx_byte"}, tx_got, {4'h0, d});
    chk({tag, "_busy_tx"}, busy, 1);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_tx_rdy_at_fall"}, tx_rdy, 1);
    chk({tag, "_tx_pulses"}, n_tx - t0, 1);
  endtask

  initial begin
    logic [3:0] d;
    int         w;

    // Reset state
    idle(2);
    @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_pulses", {core_start, tx_start}, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_led", led, 0);
    chk("rst_busy_ovr", {busy, overrun}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Image A: full random image with byte0 = A5, then digit 3
    rand_img();
    img[0] = 8'hA5;
    clear_log();
    send(img[0]);
    idle(9);
    chk("a_first_byte_bits", {wr_data[7], wr_data[6], wr_data[5], wr_data[4],
                              wr_data[3], wr_data[2], wr_data[1], wr_data[0]}, 8'hA5);
    send_img(1, 97);
    wait_start("a", 0);
    check_image("a");
    chk("a_overrun", overrun, 0);
    classify("a", 4'd3);

    // Image B: back-to-back bytes, then an overflow triple
    rand_img();
    clear_log();
    send(img[0]);
    w = strobe_cyc;
    idle(1);
    send(img[1]);
    idle(20);
    chk("b2b_latency", wr_cyc[0] - w, 1);
    chk("b2b_wr_count", wr_addr.size(), 16);
    chk("b2b_bits", bad_writes(16), 0);
    chk("b2b_overrun", overrun, 0);
    send(img[2]);
    send(img[3]);
    send(8'h5A);
    idle(20);
    chk("ovf_overrun", overrun, 1);
    chk("ovf_wr_count", wr_addr.size(), 32);
    send_img(4, 97);
    wait_start("b", n_start);
    check_image("b");
    d = 4'(1 + $urandom_range(0, 8));
    classify("b", d);
    chk("b_overrun_sticky", overrun, 1);

    // Image C: reset in the middle of unpacking the 40th byte
    rand_img();
    send_img(0, 38);
    send(img[39]);
    idle(2);
    @(posedge clk);
    #1 chk("c_pre_reset_we", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("c_rst_we", ram_we, 0);
    chk("c_rst_addr", ram_addr, 0);
    chk("c_rst_led_tx", {led, tx_data}, 0);
    chk("c_rst_busy_ovr", {busy, overrun}, 0);
    idle(2);
    #1 rst_n = 1'b1;

    // Image D: fresh image from address 0, stray byte during compute
    rand_img();
    clear_log();
    send_img(0, 97);
    wait_start("d", n_start);
    check_image("d");
    chk("d_overrun_pre", overrun, 0);
    w = wr_addr.size();
    send(8'hFF);
    idle(5);
    chk("d_compute_no_write", wr_addr.size(), w);
    chk("d_compute_overrun", overrun, 1);
    d = 4'($urandom_range(0, 9));
    classify("d", d);
    @(posedge clk);
    #1 core_done = 1'b1;
    core_digit = 4'((int'(d) + 1) % 10);
    @(posedge clk);
    #1 core_done = 1'b0;
    idle(3);
    chk("d_done_ignored_led", led, {4'h0, d});

    // Image E: next image starts again at bit address 0
    rand_img();
    clear_log();
    send(img[0]);
    idle(12);
    chk("e_wr_count", wr_addr.size(), 8);
    chk("e_bits", bad_writes(8), 0);

    chk("single_cycle_pulses", n_dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
